exception_coprocessor: RTL and testbench
========================================

# exception_coprocessor

Coprocessor-0 exception responder: the consumer end of the per-stage exception bundle (`exception`, `ExcCode`, `EPC`, `BD`) that fetch and later stages raise and carry down the pipeline. It sits beside the memory stage. It arbitrates hardware interrupts against the synchronous exception carried by the instruction there, commits SR/Cause/EPC, and drives `handle_exception` back to fetch (redirect to 0x4180) and `EPC_out` for `eret`. It also serves `mfc0`/`mtc0` register access.

## Interface
- `PRID`, default 32'h5335_0052: read-only PRId value.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  memory-stage slot holds a real instruction, not a bubble.
- `exception`  in  1  memory-stage instruction carries an exception.
- `ExcCode`  in  5  exception code, using the shared ExcCode macros.
- `EPC_in`  in  32  word-aligned victim PC, already delay-slot adjusted.
- `BD`  in  1  victim sits in a branch delay slot.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `eret`  in  1  memory-stage instruction is `eret`.
- `we`  in  1  `mtc0` write enable.
- `addr`  in  5  CP0 register number for read and write.
- `wdata`  in  32  `mtc0` data.
- `rdata`  out  32  `mfc0` data, combinational.
- `handle_exception`  out  1  take the exception this cycle: flush and redirect fetch.
- `EPC_out`  out  32  current EPC, used as the `eret` target.
- `EXL`  out  1  currently inside a handler.

## Operation
- **Registers.**
  - SR(12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause(13): BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - EPC(14): bits [1:0] always 0.
  - PRId(15): constant `PRID`.
  - Any other `addr` reads 0.
- **IP update.** `IP <= HWInt` every cycle, unconditionally.
- **Interrupt request.** `int_req = valid & IE & ~EXL & |(IM & IP)`. It uses the registered IP.
- **Exception request.** `exc_req = valid & exception & ~EXL`.
- **Output.** `handle_exception = int_req | exc_req`, combinational.
- **Priority.**
  - Interrupt wins over a simultaneous exception. The committed code is `Int` (0) and the victim's own exception is discarded.
  - `handle_exception` overrides `eret` and `we` in the same cycle; the faulting instruction never commits.
- **Accept (next edge).** `EXL <= 1`, `Cause.BD <= BD`, `Cause.ExcCode <= (int_req ? Int : ExcCode)`, `EPC <= {EPC_in[31:2],2'b00}`.
- **eret** (when `~handle_exception`): `EXL <= 0`. `EPC_out` presents EPC continuously; the pipeline uses it as the jump target.
- **mtc0** (when `~handle_exception`):
  - SR: writes IM, EXL and IE only.
  - EPC: writes `wdata[31:2]`.
  - Cause and PRId: writes ignored.
  - `eret` and `we` asserted together: both take effect.
- **Read.** `rdata` reflects register state before this cycle's edge, so a same-cycle write is not bypassed.
- **Idle.** Neither request nor write: all state holds except IP.

## Timing
- **Reset** (`reset`=0, asynchronous): SR = 0, Cause = 0, EPC = 0. Consequently `handle_exception` = 0, `EXL` = 0, `EPC_out` = 0 and `rdata` = 0 (unless `addr` = 15).
- **HWInt latency.** HWInt asserted before edge N sets IP at edge N; `handle_exception` rises in cycle N, after that edge.
- **HWInt deassertion.** Clears IP at the next edge. A one-cycle pulse is therefore seen for exactly one cycle.
- **Exception latency.** Same cycle: `handle_exception` is a combinational function of the inputs plus state.
- **EXL effect.** EXL = 1 masks both interrupts and exceptions. The cycle after an accept, `handle_exception` is 0 even if inputs persist.
- **Reset mid-handler.** Clears EXL immediately; no further accept happens until `reset` releases.

## Structure
- Reuse the shared ExcCode macro file for `Int`, `AdEL`, etc.
- Add CP0 register-number macros (`CP0_SR` = 12, `CP0_CAUSE` = 13, `CP0_EPC` = 14, `CP0_PRID` = 15) and SR/Cause bit-position macros to the same shared utility area.
- Single flat module; no sub-module. The request/priority logic is a few assigns.

## Test plan
- **Reset and PRId.** Hold `reset`=0 → SR, Cause and EPC read 0 and `handle_exception`=0. Release, then `addr`=15 → `rdata`=32'h53350052.
- **Synchronous exception.** `valid`=1, `exception`=1, `ExcCode`=4, `EPC_in`=0x3008, `BD`=1 → `handle_exception`=1 that cycle. Next cycle: Cause = 0x80000010, EPC = 0x3008, EXL=1, `handle_exception`=0.
- **Interrupt beats exception.** `mtc0` SR = 0x0000_0401 (IM0, IE). Then HWInt=6'b000001 plus an exception with code 12 in the same cycle → `handle_exception`=1 one cycle after HWInt. Cause.ExcCode=0, Cause.IP=0x01.
- **Masking.** With IE=0, or IM=0, or EXL=1, or `valid`=0, HWInt=6'h3F → `handle_exception` stays 0. Cause.IP still reads 6'h3F.
- **eret.** From EXL=1, EPC=0x3100: `eret`=1 → EXL=0 next cycle and `EPC_out`=0x3100 throughout. `eret` plus an exception in the same cycle → exception taken and EXL stays 1.
- **mtc0 semantics.** Write EPC with 0x3007 → reads 0x3004. Write Cause with 0xFFFFFFFF → Cause unchanged. Assert `reset`=0 with EXL=1 → EXL=0 without waiting for a clock edge.

Source files
------------

// File: rtl/exception_coprocessor_pkg.sv
// exception_coprocessor_pkg
//   Shared CP0 definitions: exception codes (Cause.ExcCode values), CP0
//   register numbers, SR/Cause bit positions and helpers that pack the
//   architectural register images returned by mfc0.
package exception_coprocessor_pkg;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR bit positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  // Cause bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  function automatic logic [31:0] sr_word(input logic [5:0] im,
                                          input logic       exl,
                                          input logic       ie);
    logic [31:0] w;
    w = '0;
    w[SR_IM_HI:SR_IM_LO] = im;
    w[SR_EXL]            = exl;
    w[SR_IE]             = ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD]                    = bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exc;
    return w;
  endfunction

endpackage

// File: rtl/exception_coprocessor.sv
// exception_coprocessor
//   CP0 exception responder beside the memory stage. Arbitrates level
//   interrupts against the synchronous exception of the memory-stage
//   instruction, commits SR/Cause/EPC on accept, serves mfc0/mtc0 and eret.
// Ports:
//   clk, reset (async, active-low)
//   valid, exception, ExcCode[4:0], EPC_in[31:0], BD : memory-stage bundle
//   HWInt[5:0]        : level-sensitive interrupt lines
//   eret, we, addr[4:0], wdata[31:0] : eret / mtc0 controls
//   rdata[31:0]       : mfc0 data (combinational, pre-edge state)
//   handle_exception  : flush and redirect fetch this cycle
//   EPC_out[31:0]     : eret target
//   EXL               : handler in progress
module exception_coprocessor
  import exception_coprocessor_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h5335_0052
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        exception,
  input  logic [4:0]  ExcCode,
  input  logic [31:0] EPC_in,
  input  logic        BD,
  input  logic [5:0]  HWInt,
  input  logic        eret,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        handle_exception,
  output logic [31:0] EPC_out,
  output logic        EXL
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic        cause_bd;
  logic [4:0]  cause_exc;
  logic [29:0] epc;

  logic int_req;
  logic exc_req;

  // Low EPC_in bits are forced to zero on commit.
  logic unused_epc_lo;
  assign unused_epc_lo = ^EPC_in[1:0];

  // IP is the registered copy of HWInt, so an interrupt is seen one edge
  // after the line rises.
  assign int_req          = valid & ie & ~exl & (|(im & ip));
  assign exc_req          = valid & exception & ~exl;
  assign handle_exception = int_req | exc_req;

  assign EXL     = exl;
  assign EPC_out = {epc, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im        <= '0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      ip        <= '0;
      cause_bd  <= 1'b0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      ip <= HWInt;
      if (handle_exception) begin
        // Accept: the victim's eret/mtc0 never commits.
        exl       <= 1'b1;
        cause_bd  <= BD;
        cause_exc <= int_req ? EXC_INT : ExcCode;
        epc       <= EPC_in[31:2];
      end else begin
        if (we && addr == CP0_SR) begin
          im  <= wdata[SR_IM_HI:SR_IM_LO];
          exl <= wdata[SR_EXL];
          ie  <= wdata[SR_IE];
        end
        if (we && addr == CP0_EPC) begin
          epc <= wdata[31:2];
        end
        // Placed last so eret clears EXL even alongside an SR write.
        if (eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CP0_SR:    rdata = sr_word(im, exl, ie);
      CP0_CAUSE: rdata = cause_word(cause_bd, ip, cause_exc);
      CP0_EPC:   rdata = {epc, 2'b00};
      CP0_PRID:  rdata = PRID;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_coprocessor.sv
module tb_exception_coprocessor;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        exception;
  logic [4:0]  ExcCode;
  logic [31:0] EPC_in;
  logic        BD;
  logic [5:0]  HWInt;
  logic        eret;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        handle_exception;
  logic [31:0] EPC_out;
  logic        EXL;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expected value pushed with the stimulus, popped at sampling.
  logic [31:0] exp_q[$];
  logic [31:0] e;

  exception_coprocessor #(.PRID(32'h5335_0052)) dut (
    .clk(clk), .reset(reset), .valid(valid), .exception(exception),
    .ExcCode(ExcCode), .EPC_in(EPC_in), .BD(BD), .HWInt(HWInt),
    .eret(eret), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .handle_exception(handle_exception), .EPC_out(EPC_out), .EXL(EXL)
  );

  always #5 clk = ~clk;

  // Advance through one rising edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; exception = 0; ExcCode = 0; EPC_in = 0; BD = 0;
    eret = 0; we = 0; addr = 0; wdata = 0;
  endtask

  task automatic test_reset();
    reset = 0; HWInt = 0;
    idle_inputs();
    step(); step();
    for (int a = 12; a <= 14; a++) begin
      addr = a[4:0];
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata !== e) begin n_bad++; $display("FAIL reset_reg%0d got %h want %h", a, rdata, e); end
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL reset_hx got %h want %h", handle_exception, e); end
    reset = 1;
    step();
    addr = 5'd15;
    exp_q.push_back(32'h5335_0052);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL prid got %h want %h", rdata, e); end
  endtask

  task automatic test_sync_exception();
    valid = 1; exception = 1; ExcCode = 5'd4; EPC_in = 32'h3008; BD = 1;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL exc_hx got %h want %h", handle_exception, e); end
    step();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    addr = 5'd13;
    exp_q.push_back(32'h8000_0010);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL exc_masked_hx got %h want %h", handle_exception, e); end
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, EXL} !== e) begin n_bad++; $display("FAIL exc_exl got %h want %h", EXL, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL exc_cause got %h want %h", rdata, e); end
    addr = 5'd14;
    exp_q.push_back(32'h3008);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL exc_epc got %h want %h", rdata, e); end
    idle_inputs();
    eret = 1;
    step();
    eret = 0;
  endtask

  task automatic test_int_beats_exception();
    we = 1; addr = 5'd12; wdata = 32'h0000_0401;
    step();
    we = 0;
    HWInt = 6'b000001;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL int_early_hx got %h want %h", handle_exception, e); end
    step();
    valid = 1; exception = 1; ExcCode = 5'd12; EPC_in = 32'h4000; BD = 0;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL int_hx got %h want %h", handle_exception, e); end
    step();
    idle_inputs();
    addr = 5'd13;
    exp_q.push_back(32'h0000_0400);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL int_cause got %h want %h", rdata, e); end
    addr = 5'd12;
    exp_q.push_back(32'h0000_0403);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL int_sr got %h want %h", rdata, e); end
    HWInt = 0; eret = 1;
    step();
    eret = 0;
  endtask

  task automatic test_masking();
    // IE=0, all IM set
    we = 1; addr = 5'd12; wdata = 32'h0000_FC00;
    step();
    we = 0; HWInt = 6'h3F;
    step();
    valid = 1;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL mask_ie_hx got %h want %h", handle_exception, e); end
    addr = 5'd13;
    exp_q.push_back(32'h0000_FC00);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL mask_ip got %h want %h", rdata, e); end
    // IM=0, IE=1
    valid = 0; we = 1; addr = 5'd12; wdata = 32'h0000_0001;
    step();
    we = 0; valid = 1;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL mask_im_hx got %h want %h", handle_exception, e); end
    // valid=0 with interrupts fully enabled
    valid = 0; we = 1; wdata = 32'h0000_FC01;
    step();
    we = 0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL mask_valid_hx got %h want %h", handle_exception, e); end
    valid = 1;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL mask_open_hx got %h want %h", handle_exception, e); end
    step();
    // EXL=1 now masks the same request
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL mask_exl_hx got %h want %h", handle_exception, e); end
    idle_inputs(); HWInt = 0; eret = 1;
    step();
    eret = 0;
    // Drop IE so later tests see exceptions only
    we = 1; addr = 5'd12; wdata = 32'h0;
    step();
    we = 0;
  endtask

  task automatic test_eret();
    valid = 1; exception = 1; ExcCode = 5'd10; EPC_in = 32'h3100;
    step();
    idle_inputs();
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h3100);
    eret = 1;
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, EXL} !== e) begin n_bad++; $display("FAIL eret_pre_exl got %h want %h", EXL, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (EPC_out !== e) begin n_bad++; $display("FAIL eret_pre_epc got %h want %h", EPC_out, e); end
    step();
    eret = 0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h3100);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, EXL} !== e) begin n_bad++; $display("FAIL eret_exl got %h want %h", EXL, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (EPC_out !== e) begin n_bad++; $display("FAIL eret_epc got %h want %h", EPC_out, e); end
    // eret and exception together: exception wins
    eret = 1; valid = 1; exception = 1; ExcCode = 5'd5; EPC_in = 32'h3200;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, handle_exception} !== e) begin n_bad++; $display("FAIL eret_exc_hx got %h want %h", handle_exception, e); end
    step();
    idle_inputs();
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h3200);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, EXL} !== e) begin n_bad++; $display("FAIL eret_exc_exl got %h want %h", EXL, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (EPC_out !== e) begin n_bad++; $display("FAIL eret_exc_epc got %h want %h", EPC_out, e); end
    eret = 1;
    step();
    eret = 0;
  endtask

  task automatic test_mtc0();
    we = 1; addr = 5'd14; wdata = 32'h3007;
    exp_q.push_back(32'h3200);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL mtc0_nobypass got %h want %h", rdata, e); end
    step();
    we = 0;
    exp_q.push_back(32'h3004);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL mtc0_epc got %h want %h", rdata, e); end
    // Cause: BD=0, ExcCode=5 from the last accept, IP=0
    we = 1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    step();
    we = 0;
    exp_q.push_back(32'h0000_0014);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (rdata !== e) begin n_bad++; $display("FAIL mtc0_cause got %h want %h", rdata, e); end
    we = 1; addr = 5'd12; wdata = 32'h0000_0002;
    step();
    we = 0;
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, EXL} !== e) begin n_bad++; $display("FAIL mtc0_exl_set got %h want %h", EXL, e); end
    // Asynchronous reset: sample well before the next rising edge
    @(negedge clk);
    reset = 0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({31'b0, EXL} !== e) begin n_bad++; $display("FAIL async_reset_exl got %h want %h", EXL, e); end
    step();
    reset = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_sync_exception();
    test_int_beats_exception();
    test_masking();
    test_eret();
    test_mtc0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
